// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin select arbiter.
package rr_mux8_arbiter_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux8_arbiter_pick8.sv
// Round-robin winner search: first set bit of ereq at or above ptr, wrapping 7->0.
module rr_pick8
  import rr_mux8_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] ereq,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   idx;

  assign dbl = {ereq, ereq} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  // Scan downward so the lowest set bit of the rotated vector is kept last.
  always_comb begin
    idx = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) idx = SEL_W'(i-1);
    end
  end

  assign found  = |ereq;
  assign winner = idx + ptr;

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter owning the 8:1 select path, with a bounded hold time per owner.
module rr_mux8_arbiter
  import rr_mux8_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             dout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;

  logic [N_REQ-1:0]  ereq, ereq_oth;
  logic [SEL_W-1:0]  w_all, w_oth, grant_w;
  logic              f_all, f_oth;
  logic              grant_en, go_idle, hold_inc;

  assign ereq     = req & mask;
  assign ereq_oth = ereq & ~onehot8(sel_q);

  rr_pick8 u_pick_all (.ereq(ereq),     .ptr(ptr_q), .winner(w_all), .found(f_all));
  rr_pick8 u_pick_oth (.ereq(ereq_oth), .ptr(ptr_q), .winner(w_oth), .found(f_oth));

  always_comb begin
    grant_en = 1'b0;
    grant_w  = w_all;
    go_idle  = 1'b0;
    hold_inc = 1'b0;
    case (state_q)
      ST_IDLE: grant_en = f_all;
      ST_GRANT: begin
        if (!ereq[sel_q]) begin
          grant_en = f_all;
          go_idle  = !f_all;
        end else if (hold_q == HOLD_LAST) begin
          // Preempt only when someone else waits; otherwise the count saturates.
          grant_en = f_oth;
          grant_w  = w_oth;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (grant_en) begin
      state_q <= ST_GRANT;
      gnt_q   <= onehot8(grant_w);
      sel_q   <= grant_w;
      valid_q <= 1'b1;
      hold_q  <= '0;
      ptr_q   <= grant_w + SEL_W'(1);
    end else if (go_idle) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (hold_inc) begin
      hold_q  <= hold_q + HOLD_W'(1);
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign dout  = valid_q & d[sel_q];

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Bench: two arbiters (MAX_HOLD=1 and 4) on shared inputs, checked against a queue-free ownership model.
module tb_rr_mux8_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask, d;
  logic [7:0] gnt1, gnt4;
  logic [2:0] sel1, sel4;
  logic       valid1, valid4, dout1, dout4;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 -> MAX_HOLD=1, index 1 -> MAX_HOLD=4. owner<0 means idle.
  int owner [2];
  int ptr   [2];
  int held  [2];
  int lsel  [2];
  int maxh  [2];

  always #5 clk = ~clk;

  rr_mux8_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .d(d),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .dout(dout1)
  );

  rr_mux8_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .d(d),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .dout(dout4)
  );

  function automatic int find_next(input logic [7:0] e, input int p);
    for (int k = 0; k < 8; k++) begin
      if (e[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1; ptr[m] = 0; held[m] = 0; lsel[m] = 0;
    end
  endtask

  task automatic give(input int m, input int w);
    owner[m] = w; held[m] = 1; lsel[m] = w; ptr[m] = (w + 1) % 8;
  endtask

  // held counts cycles the owner has had the grant so far.
  task automatic model_step();
    logic [7:0] e, others;
    int w;
    e = req & mask;
    for (int m = 0; m < 2; m++) begin
      if (owner[m] < 0 || !e[owner[m]]) begin
        w = find_next(e, ptr[m]);
        if (w >= 0) give(m, w);
        else owner[m] = -1;
      end else begin
        others = e;
        others[owner[m]] = 1'b0;
        w = find_next(others, ptr[m]);
        if (held[m] >= maxh[m] && w >= 0) give(m, w);
        else held[m] = held[m] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    logic [7:0] eo;
    for (int m = 0; m < 2; m++) begin
      eg = (owner[m] < 0) ? 8'h00 : (8'h01 << owner[m]);
      eo = (owner[m] < 0) ? 8'h00 : {7'h0, d[lsel[m]]};
      if (m == 0) begin
        chk("gnt_h1", gnt1, eg);
        chk("sel_h1", {5'h0, sel1}, 8'(lsel[m]));
        chk("valid_h1", {7'h0, valid1}, {7'h0, owner[m] >= 0});
        chk("dout_h1", {7'h0, dout1}, eo);
      end else begin
        chk("gnt_h4", gnt4, eg);
        chk("sel_h4", {5'h0, sel4}, 8'(lsel[m]));
        chk("valid_h4", {7'h0, valid4}, {7'h0, owner[m] >= 0});
        chk("dout_h4", {7'h0, dout4}, eo);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  initial begin
    maxh[0] = 1; maxh[1] = 4;
    model_reset();
    rst_n = 1'b0; req = '0; mask = 8'hFF; d = '0;

    // Reset and idle
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single requester 5 with d[5] toggling through dout
    req = 8'h20;
    cycle();
    chk("single_gnt", gnt4, 8'h20);
    d = 8'h20; #1; chk("dout_follow_hi", {7'h0, dout4}, 8'h01);
    d = 8'h00; #1; chk("dout_follow_lo", {7'h0, dout4}, 8'h00);
    d = 8'hDF; #1; chk("dout_other_bits", {7'h0, dout4}, 8'h00);
    repeat (2) cycle();
    req = 8'h00;
    cycle();
    chk("release_idle", {7'h0, valid4}, 8'h00);
    chk("idle_sel_kept", {5'h0, sel4}, 8'h05);
    // ptr should now be 6: 6 wins over 1
    req = 8'h42;
    cycle();
    chk("ptr_after_release", gnt4, 8'h40);
    req = 8'h00;
    cycle();

    // Round robin every cycle with MAX_HOLD=1 after reset (ptr=0)
    rst_n = 1'b0; #1; model_reset(); cycle();
    rst_n = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rr_seq", {5'h0, sel1}, 8'(i % 8));
    end

    // Mid-grant asynchronous reset
    #2 rst_n = 1'b0;
    #1 chk("async_rst_gnt1", gnt1, 8'h00);
    chk("async_rst_valid4", {7'h0, valid4}, 8'h00);
    model_reset();
    cycle();
    rst_n = 1'b1; req = 8'h00;
    cycle();

    // Hold limit on MAX_HOLD=4: 0 for 4 cycles, 7 for 4, back to 0
    req = 8'h81;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("hold_seq", {5'h0, sel4}, (i % 8) < 4 ? 8'h00 : 8'h07);
    end
    req = 8'h01;
    repeat (10) cycle();
    chk("hold_alone", gnt4, 8'h01);

    // Back-to-back handoff 2 -> 4
    req = 8'h04; cycle(); cycle();
    req = 8'h10; cycle();
    chk("handoff_gnt", gnt4, 8'h10);
    chk("handoff_valid", {7'h0, valid4}, 8'h01);

    // Masking
    req = 8'h0C; mask = 8'hF7; cycle(); cycle();
    chk("mask_only2", gnt4, 8'h04);
    mask = 8'hF3; cycle();
    chk("mask_drop_idle", {7'h0, valid4}, 8'h00);
    mask = 8'hFF; req = 8'h00; cycle();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      req  = 8'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      d    = 8'($urandom);
      if ($urandom_range(0, 5) == 0) req = 8'h00;
      cycle();
      d = 8'($urandom); #1;
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
